// File: rtl/tmc_nios2_irq_agg.sv
// tmc_nios2_irq_agg
//   Interrupt aggregator for the Nios II. Collects NUM_SRC interrupt lines from
//   the interval timers and other TMC peripherals. Each source can be captured
//   on its level or on its rising edge. Captured events are latched as pending,
//   can be masked, forced by software and cleared by writing 1. The result is a
//   single registered irq.
//
//   Optional build macro IRQ_AGG_SYNC_EN: when defined, each irq_in bit passes
//   through a two-flop synchronizer before capture. This raises input-to-irq
//   latency from 2 to 4 edges. When the macro is undefined, irq_in must be
//   synchronous to clk.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     Avalon word address (3 bits)
//   chipselect  Avalon select
//   write_n     Avalon write strobe, active-low
//   writedata   Avalon write data (16 bits)
//   readdata    Avalon read data, registered, 1-cycle latency
//   irq_in      source interrupt lines, active-high (NUM_SRC bits)
//   irq         aggregated, masked, registered interrupt to the CPU
//
// Register map (16-bit, bits >= NUM_SRC read 0 and ignore writes)
//   0 PENDING  read pending, write 1 to clear
//   1 MASK     read/write
//   2 EDGE_SEL read/write, 1 = rising edge, 0 = level
//   3 RAW      read-only captured input
//   4 VECTOR   read-only {active, 11'b0, idx[3:0]}
//   5 FORCE    write 1 sets pending, reads 0
//   6,7        read 0, writes ignored

module tmc_nios2_irq_agg #(
  parameter int          NUM_SRC    = 8,
  parameter logic [15:0] MASK_RESET = 16'h0000,
  parameter logic [15:0] EDGE_RESET = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq
);

  // Bits that correspond to implemented sources. All internal registers are
  // kept at 16 bits and ANDed with this mask. As a result, unimplemented bits
  // stay 0 and read back as 0 for every legal NUM_SRC, including 16.
  localparam logic [15:0] SRC_BITS = 16'((32'd1 << NUM_SRC) - 32'd1);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_RAW     = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_FORCE   = 3'd5;

  // Lowest-numbered set bit of act. Returns 0 when act is empty.
  function automatic logic [3:0] prio_idx(input logic [15:0] act);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (act[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  logic [15:0] irq_in_ext;
  logic [15:0] s_in;
  logic [15:0] prev;
  logic [15:0] pending;
  logic [15:0] mask_reg;
  logic [15:0] edge_sel;

  logic        wr_en;
  logic        wr_pending;
  logic        wr_mask;
  logic        wr_edge;
  logic        wr_force;
  logic [15:0] w1c;
  logic [15:0] frc;
  logic [15:0] set;
  logic [15:0] act;
  logic [3:0]  vec_idx;
  logic        vec_active;
  logic [15:0] rd_mux;

  always_comb begin
    irq_in_ext                = '0;
    irq_in_ext[NUM_SRC-1:0]   = irq_in;
  end

`ifdef IRQ_AGG_SYNC_EN
  logic [15:0] sync_p0;
  logic [15:0] sync_p1;

  // Two-flop synchronizer stage boundary: irq_in -> sync_p0 -> sync_p1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= irq_in_ext & SRC_BITS;
      sync_p1 <= sync_p0;
    end
  end

  assign s_in = sync_p1;
`else
  assign s_in = irq_in_ext & SRC_BITS;
`endif

  assign wr_en      = chipselect && !write_n;
  assign wr_pending = wr_en && (address == ADDR_PENDING);
  assign wr_mask    = wr_en && (address == ADDR_MASK);
  assign wr_edge    = wr_en && (address == ADDR_EDGE);
  assign wr_force   = wr_en && (address == ADDR_FORCE);

  assign w1c = wr_pending ? (writedata & SRC_BITS) : 16'h0000;
  assign frc = wr_force   ? (writedata & SRC_BITS) : 16'h0000;

  // prev resets to 0. A line that is already high when reset is released
  // therefore registers as a rising edge on the first cycle.
  assign set = (edge_sel & s_in & ~prev) | (~edge_sel & s_in);

  assign act        = pending & mask_reg;
  assign vec_idx    = prio_idx(act);
  assign vec_active = |act;

  // Capture stage boundary: s_in/prev -> pending, control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= '0;
      pending  <= '0;
      mask_reg <= MASK_RESET & SRC_BITS;
      edge_sel <= EDGE_RESET & SRC_BITS;
    end else begin
      prev <= s_in;
      // Set and force are ORed in after the clear, so a new event in the
      // same cycle as a W1C keeps the bit. A level source also re-sets
      // every cycle while high, so it cannot be cleared until it drops.
      pending <= ((pending & ~w1c) | set | frc) & SRC_BITS;
      if (wr_mask) mask_reg <= writedata & SRC_BITS;
      if (wr_edge) edge_sel <= writedata & SRC_BITS;
    end
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (address)
      ADDR_PENDING: rd_mux = pending;
      ADDR_MASK:    rd_mux = mask_reg;
      ADDR_EDGE:    rd_mux = edge_sel;
      ADDR_RAW:     rd_mux = s_in;
      ADDR_VECTOR:  rd_mux = {vec_active, 11'b0, vec_idx};
      default:      rd_mux = 16'h0000;
    endcase
  end

  // Output stage boundary: act -> irq, read mux -> readdata
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 16'h0000;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= vec_active;
    end
  end

endmodule

// File: tb/tb_tmc_nios2_irq_agg.sv
// Scoreboard bench for tmc_nios2_irq_agg.
// Stimulus pushes expected readdata/irq values into queues. A monitor pops
// and compares them when the bench's delayed read/irq-sample valids arrive.
`timescale 1ns/1ps

module tb_tmc_nios2_irq_agg;

  localparam int NUM_SRC = 8;
`ifdef IRQ_AGG_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    string       nm;
    logic [15:0] val;
    logic        b;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [2:0]         address = '0;
  logic               chipselect = 1'b0;
  logic               write_n = 1'b1;
  logic [15:0]        writedata = '0;
  logic [15:0]        readdata;
  logic [NUM_SRC-1:0] irq_in = '0;
  logic               irq;

  logic read_req = 1'b0;
  logic irq_req  = 1'b0;
  logic rd_vld_p1;
  logic irq_vld_p1;
  logic snap = 1'b0;

  exp_t rd_q[$];
  exp_t irq_q[$];
  exp_t snap_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  tmc_nios2_irq_agg #(
    .NUM_SRC   (NUM_SRC),
    .MASK_RESET(16'hF00C),
    .EDGE_RESET(16'h0302)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq_in    (irq_in),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_p1  <= 1'b0;
      irq_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1  <= read_req;
      irq_vld_p1 <= irq_req;
    end
  end

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h required 0x%04h", nm, act, exp);
  endtask

  task automatic underflow(input string what);
    n_chk++;
    $display("FAIL %s: got output with empty scoreboard required an expectation", what);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rd_vld_p1) begin
      if (rd_q.size() == 0) underflow("rd_q");
      else begin
        e = rd_q.pop_front();
        cmp(e.nm, readdata, e.val);
      end
    end
    if (irq_vld_p1) begin
      if (irq_q.size() == 0) underflow("irq_q");
      else begin
        e = irq_q.pop_front();
        cmp(e.nm, {15'b0, irq}, e.val);
      end
    end
  end

  always @(posedge snap) begin
    exp_t e;
    if (snap_q.size() == 0) underflow("snap_q");
    else begin
      e = snap_q.pop_front();
      cmp({e.nm, "_readdata"}, readdata, e.val);
      cmp({e.nm, "_irq"}, {15'b0, irq}, {15'b0, e.b});
    end
  end

  // Each bus task consumes exactly one rising edge and returns at a negedge.
  task automatic cycle();
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_req   = 1'b0;
    irq_req    = 1'b0;
    address    = '0;
    writedata  = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cycle();
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string nm);
    address    = a;
    chipselect = 1'b1;
    read_req   = 1'b1;
    rd_q.push_back('{nm, exp, 1'b0});
    cycle();
  endtask

  // Expect irq value after the rising edge consumed by the next bus task.
  task automatic exp_irq(input logic b, input string nm);
    irq_q.push_back('{nm, {15'b0, b}, b});
    irq_req = 1'b1;
  endtask

  task automatic check_reset_regs(input string tag);
    logic [15:0] e;
    exp_irq(1'b0, {tag, "_irq"});
    for (int a = 0; a < 8; a++) begin
      e = (a == 1) ? 16'h000C : (a == 2) ? 16'h0002 : 16'h0000;
      rd(3'(a), e, $sformatf("%s_reg%0d", tag, a));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cycle();

    check_reset_regs("rst");

    // Level capture
    wr(2, 16'h0000);
    wr(1, 16'h0004);
    irq_in[2] = 1'b1;
    for (int k = 0; k < LAT - 1; k++) begin
      exp_irq(1'b0, $sformatf("lvl_irq_low%0d", k));
      cycle();
    end
    exp_irq(1'b1, "lvl_irq_high");
    cycle();
    wr(0, 16'h0004);
    rd(0, 16'h0004, "lvl_w1c_held");
    irq_in[2] = 1'b0;
    repeat (LAT - 2) cycle();
    exp_irq(1'b1, "lvl_irq_at_w1c");
    wr(0, 16'h0004);
    exp_irq(1'b0, "lvl_irq_fall");
    rd(0, 16'h0000, "lvl_pend_clr");

    // Edge capture
    wr(2, 16'h0001);
    wr(1, 16'h0001);
    irq_in[0] = 1'b1;
    cycle();
    irq_in[0] = 1'b0;
    repeat (LAT) cycle();
    exp_irq(1'b1, "edge_irq");
    rd(0, 16'h0001, "edge_pend");
    irq_in[0] = 1'b1;
    for (int k = 0; k < LAT - 2; k++) begin
      cycle();
      irq_in[0] = 1'b0;
    end
    wr(0, 16'h0001);
    irq_in[0] = 1'b0;
    rd(0, 16'h0001, "edge_set_wins");
    repeat (LAT) cycle();
    exp_irq(1'b1, "edge_irq_at_w1c");
    wr(0, 16'h0001);
    exp_irq(1'b0, "edge_w1c_irq");
    rd(0, 16'h0000, "edge_w1c_pend");

    // Force and vector
    wr(1, 16'h00FF);
    wr(5, 16'h00A0);
    exp_irq(1'b1, "frc_irq");
    rd(0, 16'h00A0, "frc_pend");
    rd(4, 16'h8005, "frc_vec5");
    rd(5, 16'h0000, "frc_reads0");
    wr(0, 16'h0020);
    rd(4, 16'h8007, "frc_vec7");
    wr(0, 16'h0080);
    exp_irq(1'b0, "frc_irq_off");
    rd(4, 16'h0000, "frc_vec_none");

    // Mask gating
    wr(1, 16'h0000);
    wr(5, 16'h0010);
    rd(0, 16'h0010, "msk_pend");
    exp_irq(1'b0, "msk_irq_masked");
    rd(4, 16'h0000, "msk_vec_masked");
    exp_irq(1'b0, "msk_irq_at_wr");
    wr(1, 16'h0010);
    exp_irq(1'b1, "msk_irq_next");
    rd(4, 16'h8004, "msk_vec4");
    rd(6, 16'h0000, "addr6_zero");
    rd(7, 16'h0000, "addr7_zero");

    // Upper bits beyond NUM_SRC
    wr(0, 16'h0010);
    wr(5, 16'hFF00);
    rd(0, 16'h0000, "hi_force_ignored");
    wr(1, 16'hFF00);
    rd(1, 16'h0000, "hi_mask_ignored");
    wr(2, 16'hFFFF);
    rd(2, 16'h00FF, "hi_edge_trunc");

    // RAW, then asynchronous reset mid-operation
    wr(2, 16'h0000);
    wr(1, 16'h00FF);
    wr(5, 16'h00FF);
    rd(0, 16'h00FF, "pre_rst_pend");
    irq_in = 8'h5A;
    repeat (LAT - 2) cycle();
    exp_irq(1'b1, "pre_rst_irq");
    rd(3, 16'h005A, "raw_5a");
    #2;
    reset_n = 1'b0;
    irq_in  = '0;
    #1;
    snap_q.push_back('{"async_rst", 16'h0000, 1'b0});
    snap = 1'b1;
    #1;
    snap = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    check_reset_regs("rst2");

    cycle();
    cycle();
    if (rd_q.size() != 0 || irq_q.size() != 0 || snap_q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: got %0d/%0d/%0d left required 0/0/0",
               rd_q.size(), irq_q.size(), snap_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
